// File: rtl/plot_sink_fb.sv
// Plot-request consumer: FIFO-buffered writes into a WIDTHxHEIGHT framebuffer with collision detect,
// bulk clear and a 1-cycle scanout read port. Define PLOT_SINK_XOR_EN to store old^new on writes.
module plot_sink_fb #(
  parameter int FIFO_DEPTH  = 8,
  parameter int WIDTH       = 160,
  parameter int HEIGHT      = 120,
  parameter int COLOUR_BITS = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             x,
  input  logic [6:0]             y,
  input  logic [COLOUR_BITS-1:0] colour,
  input  logic                   plot,
  output logic                   ready,
  input  logic                   clear,
  output logic                   busy,
  output logic                   collision,
  input  logic                   collision_clr,
  output logic                   dropped,
  input  logic [7:0]             rd_x,
  input  logic [6:0]             rd_y,
  output logic [COLOUR_BITS-1:0] rd_colour
);

  localparam int ADDR_W = 15;
  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_CLEAR} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]      addr;
    logic [COLOUR_BITS-1:0] col;
  } req_t;

  req_t                   fifo_mem [FIFO_DEPTH];
  logic [COLOUR_BITS-1:0] fb_mem   [NPIX];

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  req_t                   cur_q, cur_d;
  logic [ADDR_W-1:0]      clr_cnt_q, clr_cnt_d;
  logic                   clear_pend_q, clear_pend_d;
  logic                   collision_q, collision_d;
  logic                   dropped_q, dropped_d;
  logic [COLOUR_BITS-1:0] rd_colour_q, rd_colour_d;
  logic [COLOUR_BITS-1:0] old_q, old_d;

  logic                   in_range, accept, push, pop, flush, fifo_full, fifo_ne, coll_set;
  logic [ADDR_W-1:0]      plot_addr, rd_addr, ram_waddr;
  logic                   ram_we;
  logic [COLOUR_BITS-1:0] ram_wdata;

  always_comb begin
    in_range  = ({24'd0, x} < 32'(WIDTH)) && ({25'd0, y} < 32'(HEIGHT));
    plot_addr = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
    rd_addr   = ADDR_W'(rd_y) * ADDR_W'(WIDTH) + ADDR_W'(rd_x);
    fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    fifo_ne   = (count_q != '0);
    ready     = !fifo_full && !clear_pend_q && (state_q != S_CLEAR);
    busy      = fifo_ne || (state_q != S_IDLE) || clear_pend_q;
    accept    = plot && ready;
    push      = accept && in_range;
  end

  // Next-state: the FSM owns the RAM write port and the FIFO pop side.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    clr_cnt_d    = clr_cnt_q;
    clear_pend_d = clear_pend_q || clear;
    pop          = 1'b0;
    flush        = 1'b0;
    coll_set     = 1'b0;
    ram_we       = 1'b0;
    ram_waddr    = cur_q.addr;
`ifdef PLOT_SINK_XOR_EN
    ram_wdata    = old_q ^ cur_q.col;
`else
    ram_wdata    = cur_q.col;
`endif
    case (state_q)
      S_IDLE: begin
        if (clear_pend_q) begin
          state_d   = S_CLEAR;
          flush     = 1'b1;
          clr_cnt_d = '0;
        end else if (fifo_ne) begin
          pop     = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_WRITE;
      S_WRITE: begin
        ram_we   = 1'b1;
        coll_set = (old_q != '0) && (cur_q.col != '0);
        if (clear_pend_q) begin
          state_d   = S_CLEAR;
          flush     = 1'b1;
          clr_cnt_d = '0;
        end else if (fifo_ne) begin
          pop     = 1'b1;
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt_q;
        ram_wdata = '0;
        if (clear) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q == ADDR_W'(NPIX - 1)) begin
          clear_pend_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) cur_d = fifo_mem[rd_ptr_q];

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // Set beats clear when both land on the same cycle.
    collision_d = coll_set ? 1'b1 : (collision_clr ? 1'b0 : collision_q);
    dropped_d   = (accept && !in_range) ? 1'b1 : (collision_clr ? 1'b0 : dropped_q);

    old_d       = fb_mem[cur_q.addr];
    rd_colour_d = ({17'd0, rd_addr} < 32'(NPIX)) ? fb_mem[rd_addr] : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cur_q        <= '0;
      clr_cnt_q    <= '0;
      clear_pend_q <= 1'b0;
      collision_q  <= 1'b0;
      dropped_q    <= 1'b0;
      rd_colour_q  <= '0;
      old_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cur_q        <= cur_d;
      clr_cnt_q    <= clr_cnt_d;
      clear_pend_q <= clear_pend_d;
      collision_q  <= collision_d;
      dropped_q    <= dropped_d;
      rd_colour_q  <= rd_colour_d;
      old_q        <= old_d;
    end
  end

  // Storage arrays are never reset; reset only suppresses writes so it aborts a clear mid-way.
  always_ff @(posedge clock) begin
    if (push && !reset) fifo_mem[wr_ptr_q] <= '{addr: plot_addr, col: colour};
    if (ram_we && !reset) fb_mem[ram_waddr] <= ram_wdata;
  end

  assign collision = collision_q;
  assign dropped   = dropped_q;
  assign rd_colour = rd_colour_q;

endmodule

// File: tb/tb_plot_sink_fb.sv
// Directed bench for plot_sink_fb: drives and samples on the falling clock edge.
module tb_plot_sink_fb;

  logic       clock = 1'b0;
  logic       reset, plot, clear, collision_clr;
  logic [7:0] x, rd_x;
  logic [6:0] y, rd_y;
  logic [2:0] colour, rd_colour;
  logic       ready, busy, collision, dropped;

  int checks = 0;
  int errors = 0;
  int cycles;
  logic exp_rdy;
  logic acc [20];

  always #5 clock = ~clock;

  plot_sink_fb dut (
    .clock(clock), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
    .ready(ready), .clear(clear), .busy(busy), .collision(collision),
    .collision_clr(collision_clr), .dropped(dropped), .rd_x(rd_x), .rd_y(rd_y),
    .rd_colour(rd_colour)
  );

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic plot_px(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
    int n;
    x = px; y = py; colour = pc; plot = 1'b1;
    n = 0;
    while (!ready && n < 100) begin tick(); n++; end
    check("plot_ready_wait", 32'(ready), 32'd1);
    tick();
    plot = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound, output int n);
    n = 0;
    while (busy && n < bound) begin tick(); n++; end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic read_px(input string tag, input logic [7:0] px, input logic [6:0] py,
                         input logic [2:0] exp);
    rd_x = px; rd_y = py;
    tick();
    check(tag, 32'(rd_colour), 32'(exp));
  endtask

  task automatic pulse_clr_coll();
    collision_clr = 1'b1;
    tick();
    collision_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; plot = 1'b0; clear = 1'b0; collision_clr = 1'b0;
    x = '0; y = '0; colour = '0; rd_x = '0; rd_y = '0;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_collision", 32'(collision), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    check("rst_rd_colour", 32'(rd_colour), 32'd0);

    // Blank the RAM before anything depends on its contents.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_idle("init_clear_done", 20000, cycles);

    // Single plot: busy for exactly 3 sampled cycles, then readback.
    x = 8'd5; y = 7'd7; colour = 3'b111; plot = 1'b1;
    check("p1_ready", 32'(ready), 32'd1);
    tick();
    plot = 1'b0;
    check("p1_busy_c1", 32'(busy), 32'd1);
    tick();
    check("p1_busy_c2", 32'(busy), 32'd1);
    tick();
    check("p1_busy_c3", 32'(busy), 32'd1);
    tick();
    check("p1_busy_end", 32'(busy), 32'd0);
    read_px("p1_read", 8'd5, 7'd7, 3'b111);
    check("p1_collision", 32'(collision), 32'd0);

    // Collision set, clear, and no set for a zero colour.
    plot_px(8'd10, 7'd10, 3'b100);
    wait_idle("c_idle1", 100, cycles);
    check("c_no_coll_first", 32'(collision), 32'd0);
    plot_px(8'd10, 7'd10, 3'b010);
    wait_idle("c_idle2", 100, cycles);
    check("c_coll_set", 32'(collision), 32'd1);
`ifdef PLOT_SINK_XOR_EN
    read_px("c_pix2", 8'd10, 7'd10, 3'b110);
`else
    read_px("c_pix2", 8'd10, 7'd10, 3'b010);
`endif
    pulse_clr_coll();
    check("c_coll_cleared", 32'(collision), 32'd0);
    plot_px(8'd10, 7'd10, 3'b000);
    wait_idle("c_idle3", 100, cycles);
    check("c_coll_zero_col", 32'(collision), 32'd0);
`ifdef PLOT_SINK_XOR_EN
    read_px("c_pix3", 8'd10, 7'd10, 3'b110);
`else
    read_px("c_pix3", 8'd10, 7'd10, 3'b000);
`endif

    // Burst: FIFO fills after 15 accepts, then accepts alternate with drains.
    for (int i = 0; i < 20; i++) begin
      x = 8'(20 + i); y = 7'd30; colour = 3'((i % 7) + 1); plot = 1'b1;
      exp_rdy = !(i == 15 || i == 17 || i == 19);
      acc[i] = exp_rdy;
      check($sformatf("burst_ready_%0d", i), 32'(ready), 32'(exp_rdy));
      tick();
    end
    plot = 1'b0;
    wait_idle("burst_idle", 200, cycles);
    for (int i = 0; i < 20; i++) begin
      read_px($sformatf("burst_pix_%0d", i), 8'(20 + i), 7'd30,
              acc[i] ? 3'((i % 7) + 1) : 3'b000);
    end
    check("burst_no_coll", 32'(collision), 32'd0);

    // Out-of-range requests are consumed without touching FIFO or RAM.
    x = 8'd160; y = 7'd0; colour = 3'b001; plot = 1'b1;
    check("drop1_ready", 32'(ready), 32'd1);
    tick();
    plot = 1'b0;
    check("drop1_busy", 32'(busy), 32'd0);
    check("drop1_flag", 32'(dropped), 32'd1);
    tick();
    check("drop1_busy_later", 32'(busy), 32'd0);
    pulse_clr_coll();
    check("drop_cleared", 32'(dropped), 32'd0);
    x = 8'd0; y = 7'd120; colour = 3'b001; plot = 1'b1;
    tick();
    plot = 1'b0;
    check("drop2_busy", 32'(busy), 32'd0);
    check("drop2_flag", 32'(dropped), 32'd1);
    read_px("drop_alias_0_1", 8'd0, 7'd1, 3'b000);
    read_px("drop_px_0_0", 8'd0, 7'd0, 3'b000);

    // Queue 4 plots, then clear: the queue is discarded and the whole screen blanks.
    for (int i = 0; i < 4; i++) begin
      x = 8'(40 + i); y = 7'd50; colour = 3'b101; plot = 1'b1;
      check($sformatf("q_ready_%0d", i), 32'(ready), 32'd1);
      tick();
    end
    plot = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_ready_low", 32'(ready), 32'd0);
    check("clr_busy", 32'(busy), 32'd1);
    wait_idle("clr_done", 19300, cycles);
    check("clr_length", 32'(cycles >= 19195 && cycles <= 19210), 32'd1);
    check("clr_ready_back", 32'(ready), 32'd1);
    read_px("clr_px_0_0", 8'd0, 7'd0, 3'b000);
    read_px("clr_px_159_119", 8'd159, 7'd119, 3'b000);
    read_px("clr_px_80_60", 8'd80, 7'd60, 3'b000);
    read_px("clr_px_5_7", 8'd5, 7'd7, 3'b000);
    read_px("clr_px_40_50", 8'd40, 7'd50, 3'b000);
    read_px("clr_px_43_50", 8'd43, 7'd50, 3'b000);

    // Same pixel twice: collision either way; XOR build erases it.
    pulse_clr_coll();
    plot_px(8'd3, 7'd3, 3'b101);
    plot_px(8'd3, 7'd3, 3'b101);
    wait_idle("x_idle", 100, cycles);
`ifdef PLOT_SINK_XOR_EN
    read_px("x_pix", 8'd3, 7'd3, 3'b000);
`else
    read_px("x_pix", 8'd3, 7'd3, 3'b101);
`endif
    check("x_coll", 32'(collision), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
